// File: rtl/store_merge_unit.sv
// store_merge_unit: narrowing store engine for word-organised memory.
// Byte and halfword stores use read-modify-write. Word stores write directly.
// Misaligned or reserved-size requests finish with misaligned=1 and never
// touch memory.
// Every output is decoded from registered state only, so inputs never reach
// an output combinationally.
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MG   = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           lane_data_q;
    logic [1:0]            size_q;
    logic                  mis_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  req_mis;

    // Classify the incoming request as misaligned (reserved size counts too).
    always_comb begin
        req_mis = 1'b0;
        case (size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = addr[0];
            2'b10:   req_mis = (addr[1:0] != 2'b00);
            default: req_mis = 1'b1;
        endcase
    end

    // Overlay the latched narrow data onto the word read back from memory.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = lane_data_q[7:0];
                2'd1:    merged[15:8]  = lane_data_q[7:0];
                2'd2:    merged[23:16] = lane_data_q[7:0];
                default: merged[31:24] = lane_data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = lane_data_q;
        end else begin
            merged[15:0] = lane_data_q;
        end
    end

    // State register; an asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_mis)            state_next = FIN;
                    else if (size == 2'b10) state_next = WR;
                    else                    state_next = RD;
                end
            end
            RD:      state_next = MG;
            MG:      state_next = WR;
            WR:      state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latches and the merged write word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            lane_data_q <= '0;
            size_q      <= '0;
            mis_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q      <= addr;
                        lane_data_q <= wdata[15:0];
                        size_q      <= size;
                        mis_q       <= req_mis;
                        if (size == 2'b10) data_q <= wdata;
                    end
                end
                MG:      data_q <= merged;
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign mem_re     = (state == RD);
    assign mem_we     = (state == WR);
    assign done       = (state == FIN);
    assign misaligned = (state == FIN) && mis_q;
    assign mem_addr   = busy ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata  = (state == WR) ? data_q : '0;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: table of store requests with hand-computed
// results, plus sequences for reset abort, back-to-back and busy-ignore.
module tb_store_merge_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    store_merge_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
        .size(size), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .misaligned(misaligned)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_re; junk otherwise.
    logic [31:0] rd_word;
    always @(posedge clk) begin
        mem_rdata <= mem_re ? rd_word : 32'hDEAD_DEAD;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rd;
        logic [31:0] exp_wd;
        logic        exp_mis;
        int          lat;
    } vec_t;

    logic [31:0] exp_q[$];
    logic        mis_exp_q[$];
    logic [31:0] exp_addr;
    int          n_cmp;
    int          n_fail;
    int          re_cnt;
    int          we_cnt;
    vec_t        vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample outputs on the falling edge and score them.
    task automatic monitor();
        logic [31:0] e;
        logic        m;
        forever begin
            @(negedge clk);
            if (mem_re || mem_we) chk("re_we_exclusive", {31'd0, mem_re && mem_we}, 32'd0);
            if (mem_re) begin
                re_cnt++;
                chk("rd_addr", mem_addr, exp_addr);
            end
            if (mem_we) begin
                we_cnt++;
                chk("wr_addr", mem_addr, exp_addr);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", mem_wdata, e);
                end
            end
            if (done) begin
                if (mis_exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m = mis_exp_q.pop_front();
                    chk("misaligned", {31'd0, misaligned}, {31'd0, m});
                end
            end
        end
    endtask

    // Driver: issue one request, scramble inputs while busy, time the done.
    task automatic do_req(input vec_t v, input bit pulse);
        int  re0, we0, cyc;
        bit  got;
        re0      = re_cnt;
        we0      = we_cnt;
        rd_word  = v.rd;
        exp_addr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        addr  = v.addr;
        wdata = v.wdata;
        size  = v.size;
        start = 1'b1;
        if (!v.exp_mis) exp_q.push_back(v.exp_wd);
        mis_exp_q.push_back(v.exp_mis);
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            start = pulse && (cyc == 1 || cyc == 2);
            addr  = $urandom;
            wdata = $urandom;
            size  = 2'($urandom_range(0, 3));
            got   = done;
        end
        start = 1'b0;
        chk("latency", cyc, v.lat);
        chk("re_count", re_cnt - re0, (!v.exp_mis && v.size != 2'b10) ? 1 : 0);
        chk("we_count", we_cnt - we0, v.exp_mis ? 0 : 1);
        @(negedge clk);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        if (pulse) begin
            repeat (2) begin
                @(negedge clk);
                chk("ignored_start_idle", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int d1, d2, we0;
        vec_t v;
        n_cmp   = 0;
        n_fail  = 0;
        re_cnt  = 0;
        we_cnt  = 0;
        rd_word = 32'h0;
        exp_addr = 32'h0;
        rst   = 1'b1;
        start = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        size  = 2'b00;

        //        addr          wdata          size   rd            exp_wd        mis  lat
        vecs[0]  = '{32'h103, 32'hAABBCC5A, 2'b00, 32'h11223344, 32'h5A223344, 1'b0, 4};
        vecs[1]  = '{32'h202, 32'h0000BEEF, 2'b01, 32'hDEAD1234, 32'hBEEF1234, 1'b0, 4};
        vecs[2]  = '{32'h300, 32'hCAFEF00D, 2'b10, 32'h0,        32'hCAFEF00D, 1'b0, 2};
        vecs[3]  = '{32'h401, 32'h12345678, 2'b01, 32'h0,        32'h0,        1'b1, 1};
        vecs[4]  = '{32'h402, 32'h12345678, 2'b10, 32'h0,        32'h0,        1'b1, 1};
        vecs[5]  = '{32'h500, 32'h12345678, 2'b11, 32'h0,        32'h0,        1'b1, 1};
        vecs[6]  = '{32'h600, 32'h000000EE, 2'b00, 32'h11223344, 32'h112233EE, 1'b0, 4};
        vecs[7]  = '{32'h601, 32'h12345677, 2'b00, 32'h11223344, 32'h11227744, 1'b0, 4};
        vecs[8]  = '{32'h602, 32'hFFFFFF99, 2'b00, 32'h11223344, 32'h11993344, 1'b0, 4};
        vecs[9]  = '{32'h700, 32'hFFFF5555, 2'b01, 32'h11223344, 32'h11225555, 1'b0, 4};
        vecs[10] = '{32'h701, 32'hFFFF5555, 2'b10, 32'h11223344, 32'h0,        1'b1, 1};

        fork
            monitor();
        join_none

        // Reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_re_we", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i], 1'b0);
        end

        // Start pulses during RD/MG are ignored
        do_req(vecs[0], 1'b1);

        // Reset in MG of a byte store aborts with no write
        rd_word  = 32'h55667788;
        exp_addr = 32'h900;
        @(negedge clk);
        addr  = 32'h903;
        wdata = 32'h000000AB;
        size  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        we0 = we_cnt;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_re_we", {30'd0, mem_re, mem_we}, 32'd0);
        chk("abort_done_mis", {30'd0, done, misaligned}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_write", we_cnt - we0, 0);
        do_req(vecs[1], 1'b0);

        // Start held high: second store begins the cycle after done
        v = '{32'h801, 32'h0000003C, 2'b00, 32'hA0B0C0D0, 32'hA0B03CD0, 1'b0, 4};
        rd_word  = v.rd;
        exp_addr = 32'h800;
        exp_q.push_back(v.exp_wd);
        exp_q.push_back(v.exp_wd);
        mis_exp_q.push_back(1'b0);
        mis_exp_q.push_back(1'b0);
        @(negedge clk);
        addr  = v.addr;
        wdata = v.wdata;
        size  = v.size;
        start = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (c == 5) chk("b2b_idle_gap", {31'd0, busy}, 32'd0);
            if (c == 6) begin
                chk("b2b_second_rd", {31'd0, mem_re}, 32'd1);
                start = 1'b0;
            end
        end
        chk("b2b_done1", d1, 4);
        chk("b2b_done2", d2, 9);

        repeat (2) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("mis_q_drained", mis_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
